// File: rtl/ram_fifo_ctrl.sv
// FIFO controller sequencing a simple-dual-port RAM with 1-cycle read latency.
// A 2-entry show-ahead buffer keeps m_data valid whenever m_valid is high.
module ram_fifo_ctrl #(
   parameter int ADDR_WIDTH    = 11,
   parameter int DATA_WIDTH    = 16,
   parameter int AFULL_THRESH  = 2040,
   parameter int AEMPTY_THRESH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic [DATA_WIDTH-1:0]   s_data,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic [DATA_WIDTH-1:0]   m_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [ADDR_WIDTH+1:0]   level,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [DATA_WIDTH-1:0]   ram_wr_data,
   output logic [ADDR_WIDTH-1:0]   ram_wr_addr,
   output logic                    ram_wr_en,
   output logic [ADDR_WIDTH-1:0]   ram_rd_addr,
   input  logic [DATA_WIDTH-1:0]   ram_rd_data
);

   localparam int LW = ADDR_WIDTH + 2;
   localparam logic [ADDR_WIDTH:0] DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [LW-1:0]       AFULL_C  = LW'(AFULL_THRESH);
   localparam logic [LW-1:0]       AEMPTY_C = LW'(AEMPTY_THRESH);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [ADDR_WIDTH-1:0] wr_ptr_r, rd_ptr_r;
   logic [ADDR_WIDTH:0]   ram_cnt_r;
   logic                  pending_r;
   logic [1:0]            occ_r;
   logic [DATA_WIDTH-1:0] buf0_r, buf1_r;
   logic                  s_ready_r, m_valid_r, afull_r, aempty_r;
   logic [LW-1:0]         level_r;

   logic                  wr_accept_s, pop_s, issue_s;
   logic [2:0]            credit_s;
   logic [ADDR_WIDTH:0]   ram_cnt_nxt_s;
   logic [1:0]            occ_nxt_s, slot_s;
   logic [DATA_WIDTH-1:0] buf0_nxt_s, buf1_nxt_s;
   logic [LW-1:0]         level_nxt_s;

   assign s_ready      = s_ready_r;
   assign m_valid      = m_valid_r;
   assign m_data       = buf0_r;
   assign level        = level_r;
   assign almost_full  = afull_r;
   assign almost_empty = aempty_r;
   assign ram_wr_data  = s_data;
   assign ram_wr_addr  = wr_ptr_r;
   assign ram_wr_en    = wr_accept_s;
   assign ram_rd_addr  = rd_ptr_r;

   // Handshakes, read-issue credit and next-state counts.
   always_comb begin
      wr_accept_s   = s_valid & s_ready_r;
      pop_s         = m_valid_r & m_ready;
      credit_s      = {1'b0, occ_r} + {2'b00, pending_r};
      // Issue only if the word has room once it lands, counting the pop this cycle.
      issue_s       = (ram_cnt_r != {(ADDR_WIDTH+1){1'b0}}) &&
                      (credit_s < (3'd2 + {2'b00, pop_s}));
      ram_cnt_nxt_s = ram_cnt_r + {{ADDR_WIDTH{1'b0}}, wr_accept_s}
                                - {{ADDR_WIDTH{1'b0}}, issue_s};
      occ_nxt_s     = occ_r - {1'b0, pop_s} + {1'b0, pending_r};
      level_nxt_s   = {1'b0, ram_cnt_nxt_s} + {{(LW-1){1'b0}}, issue_s}
                      + {{(LW-2){1'b0}}, occ_nxt_s};
   end

   // Output buffer: shift on pop, then land the returning RAM word at the tail.
   always_comb begin
      buf0_nxt_s = pop_s ? buf1_r : buf0_r;
      buf1_nxt_s = buf1_r;
      slot_s     = occ_r - {1'b0, pop_s};
      if (pending_r) begin
         if (slot_s == 2'd0) begin
            buf0_nxt_s = ram_rd_data;
         end else begin
            buf1_nxt_s = ram_rd_data;
         end
      end else begin
         buf1_nxt_s = buf1_r;
      end
   end

   // Pointer, count, buffer and status registers; flush mirrors reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r  <= {ADDR_WIDTH{1'b0}};
         rd_ptr_r  <= {ADDR_WIDTH{1'b0}};
         ram_cnt_r <= {(ADDR_WIDTH+1){1'b0}};
         pending_r <= 1'b0;
         occ_r     <= 2'd0;
         buf0_r    <= {DATA_WIDTH{1'b0}};
         buf1_r    <= {DATA_WIDTH{1'b0}};
         s_ready_r <= 1'b1;
         m_valid_r <= 1'b0;
         level_r   <= {LW{1'b0}};
         afull_r   <= 1'b0;
         aempty_r  <= 1'b1;
      end else if (flush) begin
         wr_ptr_r  <= {ADDR_WIDTH{1'b0}};
         rd_ptr_r  <= {ADDR_WIDTH{1'b0}};
         ram_cnt_r <= {(ADDR_WIDTH+1){1'b0}};
         pending_r <= 1'b0;
         occ_r     <= 2'd0;
         buf0_r    <= {DATA_WIDTH{1'b0}};
         buf1_r    <= {DATA_WIDTH{1'b0}};
         s_ready_r <= 1'b1;
         m_valid_r <= 1'b0;
         level_r   <= {LW{1'b0}};
         afull_r   <= 1'b0;
         aempty_r  <= 1'b1;
      end else begin
         wr_ptr_r  <= wr_accept_s ? wr_ptr_r + PTR_ONE_C : wr_ptr_r;
         rd_ptr_r  <= issue_s ? rd_ptr_r + PTR_ONE_C : rd_ptr_r;
         ram_cnt_r <= ram_cnt_nxt_s;
         pending_r <= issue_s;
         occ_r     <= occ_nxt_s;
         buf0_r    <= buf0_nxt_s;
         buf1_r    <= buf1_nxt_s;
         s_ready_r <= (ram_cnt_nxt_s < DEPTH_C);
         m_valid_r <= (occ_nxt_s != 2'd0);
         level_r   <= level_nxt_s;
         afull_r   <= (level_nxt_s >= AFULL_C);
         aempty_r  <= (level_nxt_s <= AEMPTY_C);
      end
   end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 2048x16 RAM and a reference queue.
module tb_ram_fifo_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, flush, s_valid, s_ready, m_valid, m_ready;
   logic        almost_full, almost_empty, ram_wr_en;
   logic [15:0] s_data, m_data, ram_wr_data, ram_rd_data;
   logic [12:0] level;
   logic [10:0] ram_wr_addr, ram_rd_addr;
   logic [15:0] mem [0:2047];
   logic [15:0] q[$];
   int          checks = 0;
   int          failures = 0;

   ram_fifo_ctrl dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
      .ram_wr_data(ram_wr_data), .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en),
      .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM: address sampled at the edge, data visible after it.
   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
      ram_rd_data <= mem[ram_rd_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: score handshakes against the queue, then check level/flags after the edge.
   task automatic cycle();
      logic acc, pp;
      acc = s_valid && s_ready;
      pp  = m_valid && m_ready;
      if (pp) begin
         if (q.size() > 0) chk("pop_data", 32'(m_data), 32'(q.pop_front()));
         else              chk("pop_when_empty", 32'(m_valid), 32'd0);
      end
      if (acc) q.push_back(s_data);
      @(posedge clk); #1;
      chk("level", 32'(level), 32'(q.size()));
      chk("almost_full", 32'(almost_full), 32'(q.size() >= 2040));
      chk("almost_empty", 32'(almost_empty), 32'(q.size() <= 8));
   endtask

   task automatic drain();
      s_valid = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 2200 && (q.size() > 0 || m_valid); i++) cycle();
      chk("drain_mvalid", 32'(m_valid), 32'd0);
      chk("drain_level", 32'(level), 32'd0);
   endtask

   task automatic fill_and_pend();
      s_valid = 1'b1;
      m_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         s_data = 16'h0100 + 16'(i);
         cycle();
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      cycle();
      m_ready = 1'b0;
   endtask

   task automatic write_a5_and_check(input string tag);
      s_valid = 1'b1;
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_data = 16'hA5A5 + 16'(i);
         cycle();
      end
      s_valid = 1'b0;
      chk({tag, "_mvalid"}, 32'(m_valid), 32'd1);
      chk({tag, "_head"}, 32'(m_data), 32'h0000A5A5);
      drain();
   endtask

   initial begin
      int n;
      logic a;
      rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_s_ready", 32'(s_ready), 32'd1);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_afull", 32'(almost_full), 32'd0);
      chk("rst_aempty", 32'(almost_empty), 32'd1);
      chk("rst_m_data", 32'(m_data), 32'd0);
      rst_n = 1'b1;

      // Five writes with no pop: m_valid two edges after the first accept.
      s_valid = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         s_data = 16'(i);
         cycle();
         chk("lat_mvalid", 32'(m_valid), 32'(i >= 3));
         if (i >= 3) chk("lat_head", 32'(m_data), 32'd1);
      end
      s_valid = 1'b0;
      chk("t1_level", 32'(level), 32'd5);
      chk("t1_aempty", 32'(almost_empty), 32'd1);
      drain();

      // Fill to capacity with a ramp.
      s_valid = 1'b1;
      m_ready = 1'b0;
      n = 0;
      for (int i = 0; i < 2060; i++) begin
         s_data = 16'(n);
         a = s_ready;
         cycle();
         if (a) n++;
      end
      chk("full_accepts", 32'(n), 32'd2050);
      chk("full_s_ready", 32'(s_ready), 32'd0);
      chk("full_level", 32'(level), 32'd2050);
      chk("full_afull", 32'(almost_full), 32'd1);
      for (int i = 0; i < 3; i++) begin
         s_data = 16'hBEEF;
         chk("full_wr_en", 32'(ram_wr_en), 32'd0);
         cycle();
      end

      // Drain at one word per clock.
      s_valid = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 2050; i++) begin
         chk("drain_cont", 32'(m_valid), 32'd1);
         cycle();
      end
      chk("drained_mvalid", 32'(m_valid), 32'd0);
      chk("drained_level", 32'(level), 32'd0);

      // Concurrent streaming: steady state holds 3 words, no bubbles.
      s_valid = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         s_data = 16'(i);
         if (i >= 10) begin
            chk("conc_s_ready", 32'(s_ready), 32'd1);
            chk("conc_m_valid", 32'(m_valid), 32'd1);
            chk("conc_level", 32'(level), 32'd3);
         end
         cycle();
      end
      drain();

      // Random traffic against the reference queue.
      for (int i = 0; i < 4000; i++) begin
         s_valid = 1'($urandom_range(0, 1));
         m_ready = 1'($urandom_range(0, 1));
         s_data  = 16'($urandom_range(0, 65535));
         cycle();
      end
      drain();

      // Flush with a read in flight and a write in the same cycle.
      fill_and_pend();
      flush = 1'b1;
      s_valid = 1'b1;
      s_data = 16'hDEAD;
      @(posedge clk); #1;
      flush = 1'b0;
      s_valid = 1'b0;
      q.delete();
      chk("flush_m_valid", 32'(m_valid), 32'd0);
      chk("flush_level", 32'(level), 32'd0);
      chk("flush_s_ready", 32'(s_ready), 32'd1);
      chk("flush_m_data", 32'(m_data), 32'd0);
      chk("flush_aempty", 32'(almost_empty), 32'd1);
      write_a5_and_check("post_flush");

      // Asynchronous reset pulse mid-cycle with a read in flight.
      fill_and_pend();
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      chk("arst_m_valid", 32'(m_valid), 32'd0);
      chk("arst_level", 32'(level), 32'd0);
      chk("arst_m_data", 32'(m_data), 32'd0);
      chk("arst_aempty", 32'(almost_empty), 32'd1);
      #2 rst_n = 1'b1;
      write_a5_and_check("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
